shake_absorb_ctrl: RTL

Sequencer for the absorb phase of the SHAKE core. It accepts a message byte length and a stream of `w`-bit message lanes, pads each lane on the fly with the SHAKE suffix and the final `pad10*1` bit, and hands lanes to the state absorber. It groups lanes into rate blocks of `RATE_WORDS` lanes and triggers one Keccak-f permutation per block, waiting for its completion before the next block. It sits between the message source and the Keccak state/permutation datapath, replacing ad-hoc padding counters.

---
 rtl/shake_absorb_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/shake_absorb_ctrl.sv
// Absorb-phase sequencer for the SHAKE core: pads message lanes on the fly
// (SHAKE suffix + pad10*1), groups them into rate blocks and drives the permutation handshake.
module shake_absorb_ctrl #(
    parameter int WIDTH      = 32,
    parameter int RATE_WORDS = 17,
    parameter int W          = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [WIDTH-1:0]              msg_byte_size,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [W-1:0]                  in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [W-1:0]                  out_data,
    output logic [$clog2(RATE_WORDS)-1:0] out_lane_idx,
    output logic                          perm_start,
    input  logic                          perm_done,
    output logic                          busy,
    output logic                          done
);

    localparam int               B       = W / 8;
    localparam int               LIDX_W  = $clog2(RATE_WORDS);
    localparam logic [WIDTH-1:0] B_BYTES = WIDTH'(B);
    localparam logic [7:0]       SUFFIX  = 8'h1F;
    localparam logic [7:0]       PAD_END = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ABSORB    = 2'd1,
        ST_PERM_WAIT = 2'd2,
        ST_FINISH    = 2'd3
    } state_t;

    state_t              state_r, state_s;
    logic [WIDTH-1:0]    bytes_left_r, bytes_left_s;
    logic [LIDX_W-1:0]   lane_idx_r, lane_idx_s;
    logic                padded_r, padded_s;
    logic                perm_start_r, perm_start_s;

    logic                full_s;
    logic                consume_s;
    logic                last_lane_s;
    logic                absorb_s;
    logic                hs_s;
    logic [W-1:0]        lane_s;

    // Lane classification and on-the-fly padding of the current lane
    always_comb begin
        full_s      = (bytes_left_r >= B_BYTES);
        consume_s   = (bytes_left_r != {WIDTH{1'b0}});
        last_lane_s = (lane_idx_r == LIDX_W'(RATE_WORDS - 1));
        lane_s      = {W{1'b0}};
        for (int i = 0; i < B; i++) begin
            if (full_s) begin
                lane_s[i*8 +: 8] = in_data[i*8 +: 8];
            end else if (consume_s) begin
                if (WIDTH'(i) < bytes_left_r) begin
                    lane_s[i*8 +: 8] = in_data[i*8 +: 8];
                end else if (WIDTH'(i) == bytes_left_r) begin
                    lane_s[i*8 +: 8] = SUFFIX;
                end else begin
                    lane_s[i*8 +: 8] = 8'h00;
                end
            end else if (!padded_r) begin
                lane_s[i*8 +: 8] = (i == 0) ? SUFFIX : 8'h00;
            end else begin
                lane_s[i*8 +: 8] = 8'h00;
            end
        end
        // Any non-full lane in the final slot belongs to the padded block
        lane_s[W-1 -: 8] = lane_s[W-1 -: 8] | ((last_lane_s && !full_s) ? PAD_END : 8'h00);
    end

    // Zero-latency lane handshake pass-through
    always_comb begin
        absorb_s  = (state_r == ST_ABSORB);
        out_valid = absorb_s && (consume_s ? in_valid : 1'b1);
        in_ready  = absorb_s && consume_s && out_ready;
        out_data  = absorb_s ? lane_s : {W{1'b0}};
        hs_s      = out_valid && out_ready;
    end

    // Next-state and counter update logic
    always_comb begin
        state_s      = state_r;
        bytes_left_s = bytes_left_r;
        lane_idx_s   = lane_idx_r;
        padded_s     = padded_r;
        perm_start_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s      = ST_ABSORB;
                    bytes_left_s = msg_byte_size;
                    lane_idx_s   = {LIDX_W{1'b0}};
                    padded_s     = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ABSORB: begin
                if (hs_s) begin
                    if (full_s) begin
                        bytes_left_s = bytes_left_r - B_BYTES;
                    end else if (consume_s) begin
                        bytes_left_s = {WIDTH{1'b0}};
                        padded_s     = 1'b1;
                    end else begin
                        padded_s = 1'b1;
                    end
                    if (last_lane_s) begin
                        perm_start_s = 1'b1;
                        state_s      = ST_PERM_WAIT;
                    end else begin
                        lane_idx_s = lane_idx_r + LIDX_W'(1);
                    end
                end else begin
                    state_s = ST_ABSORB;
                end
            end
            ST_PERM_WAIT: begin
                if (perm_done) begin
                    lane_idx_s = {LIDX_W{1'b0}};
                    state_s    = padded_r ? ST_FINISH : ST_ABSORB;
                end else begin
                    state_s = ST_PERM_WAIT;
                end
            end
            ST_FINISH: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            bytes_left_r <= {WIDTH{1'b0}};
            lane_idx_r   <= {LIDX_W{1'b0}};
            padded_r     <= 1'b0;
            perm_start_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            bytes_left_r <= bytes_left_s;
            lane_idx_r   <= lane_idx_s;
            padded_r     <= padded_s;
            perm_start_r <= perm_start_s;
        end
    end

    assign out_lane_idx = lane_idx_r;
    assign perm_start   = perm_start_r;
    assign busy         = (state_r != ST_IDLE);
    assign done         = (state_r == ST_FINISH);

endmodule
